// File: rtl/mems_cfg_pkg.sv
// Shared definitions for the MEMS configuration sequencer: state encoding,
// clock constant, default readback check and the readback field layout.
// Optional feature macro used by the top: MEMS_AUTO_START_EN.
package mems_cfg_pkg;

    // System clock frequency; the default cycle counts are derived from it.
    localparam int SCLK_HZ = 50_000_000;

    // Default readback check: low word must read back 3000 (0x0BB8).
    localparam logic [31:0] DEF_CHK_MASK  = 32'h0000_FFFF;
    localparam logic [31:0] DEF_CHK_VALUE = 32'h0000_0BB8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_RD,
        ST_SETTLE,
        ST_CHECK,
        ST_FAIL,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } mems_state_e;

    // Readback as returned by the SPI engine: word 1 in the upper half.
    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } readback_t;

    // Largest of three cycle counts, used to size the shared timer.
    function automatic int mems_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 2 : m;
    endfunction

endpackage

// File: rtl/mems_cycle_timer.sv
// Loadable saturating down-counter. done is high while the count is zero.
// One instance serves timeout, settle, gap and power-on delays; the owner
// reloads it on each state entry.
module mems_cycle_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    output logic          done
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise step down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mems_config_ctrl.sv
// MEMS configuration sequencer. Pulses config_mems to the SPI engine, waits
// for the readback window to close, samples {H,L} after a settle delay and
// checks it against CHK_MASK/CHK_VALUE. Failures (mismatch or timeout) are
// retried after an idle gap up to MAX_RETRY times before latching an error.
// Optional feature: define MEMS_AUTO_START_EN to launch once automatically
// POR_CYC cycles after reset.
module mems_config_ctrl
    import mems_cfg_pkg::*;
#(
    parameter int          TIMEOUT_CYC = SCLK_HZ / 10,
    parameter int          SETTLE_CYC  = 3,
    parameter int          MAX_RETRY   = 3,
    parameter int          GAP_CYC     = SCLK_HZ / 1000,
    parameter logic [31:0] CHK_MASK    = DEF_CHK_MASK,
    parameter logic [31:0] CHK_VALUE   = DEF_CHK_VALUE,
    parameter int          POR_CYC     = SCLK_HZ / 100
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear_err,
    input  logic         receive_done,
    input  logic [15:0]  receive_data_L,
    input  logic [15:0]  receive_data_H,
    output logic         config_mems,
    output logic [31:0]  readback,
    output logic         readback_valid,
    output logic         cfg_ok,
    output logic         cfg_err,
    output logic         busy,
    output logic [3:0]   retry_cnt
);

    // Timer is a down-counter loaded with N-1 so that a state lasts N cycles.
    localparam int              TW        = $clog2(mems_max3(TIMEOUT_CYC, GAP_CYC, POR_CYC));
    localparam logic [TW-1:0]   TO_LD     = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]   SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]   GAP_LD    = TW'(GAP_CYC - 1);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRY);
`ifdef MEMS_AUTO_START_EN
    // Timer comes out of reset already counting the power-on delay.
    localparam logic [TW-1:0]   TMR_RST   = TW'(POR_CYC - 1);
`else
    localparam logic [TW-1:0]   TMR_RST   = '0;
`endif

    mems_state_e    state_q, state_d;
    logic           rx_done_q, rx_done_d;
    readback_t      readback_q, readback_d;
    logic           rb_valid_q, rb_valid_d;
    logic           cfg_ok_q, cfg_ok_d;
    logic           cfg_err_q, cfg_err_d;
    logic [3:0]     retry_q, retry_d;
    logic           config_mems_q, config_mems_d;
    logic           busy_q, busy_d;
`ifdef MEMS_AUTO_START_EN
    logic           por_pend_q, por_pend_d;
`endif

    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_done;
    logic           rd_fall;

    mems_cycle_timer #(
        .W       (TW),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // The readback window closes on the falling edge of receive_done.
    assign rd_fall = rx_done_q & ~receive_done;

    // Next state, timer control and flag updates.
    always_comb begin
        state_d    = state_q;
        rx_done_d  = receive_done;
        readback_d = readback_q;
        rb_valid_d = 1'b0;
        cfg_ok_d   = cfg_ok_q;
        cfg_err_d  = cfg_err_q;
        retry_d    = retry_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef MEMS_AUTO_START_EN
        por_pend_d = por_pend_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LAUNCH;
                    retry_d = '0;
`ifdef MEMS_AUTO_START_EN
                end else if (por_pend_q && tmr_done) begin
                    state_d = ST_LAUNCH;
                    retry_d = '0;
`endif
                end
            end
            ST_LAUNCH: begin
                tmr_load = 1'b1;
                tmr_val  = TO_LD;
                state_d  = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                // A closing window beats a timeout landing in the same cycle.
                if (rd_fall) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                    state_d  = ST_SETTLE;
                end else if (tmr_done) begin
                    state_d = ST_FAIL;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    readback_d = '{hi: receive_data_H, lo: receive_data_L};
                    rb_valid_d = 1'b1;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((readback_q & CHK_MASK) == CHK_VALUE) begin
                    cfg_ok_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d  = retry_q + 4'd1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    state_d  = ST_GAP;
                end else begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_ERROR;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                if (start) begin
                    retry_d = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    cfg_err_d = 1'b0;
                    retry_d   = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every launch starts with a fresh verdict; any launch consumes the
        // pending power-on request.
        if (state_d == ST_LAUNCH) begin
            cfg_ok_d = 1'b0;
`ifdef MEMS_AUTO_START_EN
            por_pend_d = 1'b0;
`endif
        end
    end

    // Registered outputs decoded from the next state so they line up with it.
    always_comb begin
        config_mems_d = (state_d == ST_LAUNCH);
        busy_d        = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
    end

    // State and output registers.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rx_done_q     <= 1'b0;
            readback_q    <= '0;
            rb_valid_q    <= 1'b0;
            cfg_ok_q      <= 1'b0;
            cfg_err_q     <= 1'b0;
            retry_q       <= '0;
            config_mems_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_done_q     <= rx_done_d;
            readback_q    <= readback_d;
            rb_valid_q    <= rb_valid_d;
            cfg_ok_q      <= cfg_ok_d;
            cfg_err_q     <= cfg_err_d;
            retry_q       <= retry_d;
            config_mems_q <= config_mems_d;
            busy_q        <= busy_d;
        end
    end

`ifdef MEMS_AUTO_START_EN
    // Power-on launch request, armed by reset.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            por_pend_q <= 1'b1;
        end else begin
            por_pend_q <= por_pend_d;
        end
    end
`endif

    assign config_mems    = config_mems_q;
    assign readback       = readback_q;
    assign readback_valid = rb_valid_q;
    assign cfg_ok         = cfg_ok_q;
    assign cfg_err        = cfg_err_q;
    assign busy           = busy_q;
    assign retry_cnt      = retry_q;

endmodule
